// File: rtl/inst_fetcher_if.sv
// Instruction memory request/response bus: the fetcher drives address/valid,
// and memory returns data with ready in the same cycle.
interface inst_fetcher_if;
  logic [31:0] inst_mem_out_addr;
  logic        inst_mem_out_valid;
  logic [31:0] inst_mem_out_data;
  logic        inst_mem_out_ready;

  modport master (
    output inst_mem_out_addr,
    output inst_mem_out_valid,
    input  inst_mem_out_data,
    input  inst_mem_out_ready
  );

  modport slave (
    input  inst_mem_out_addr,
    input  inst_mem_out_valid,
    output inst_mem_out_data,
    output inst_mem_out_ready
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher with a small direct-mapped, one-word-per-line cache.
// Hits complete from the cache; misses issue one memory request and fill the line.
module inst_fetcher #(
  parameter int unsigned CACHE_LINES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetcher_reset,
  input  logic [31:0]   pc,
  input  logic          cache_flush,
  output logic          fetcher_completed,
  output logic [31:0]   instruction,
  inst_fetcher_if.master mem
);

  localparam int unsigned WORD_W = 30;
  localparam int unsigned IDX_W  = $clog2(CACHE_LINES);
  localparam int unsigned TAG_W  = WORD_W - IDX_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] REQ    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [WORD_W-1:0]      fetch_word;
  logic [CACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]       tag_mem  [CACHE_LINES];
  logic [31:0]            data_mem [CACHE_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             latch_pc;
  logic             load_hit;
  logic             fill;
  logic             unused_pc_bits;

  // Byte offset within the word never affects the fetch.
  assign unused_pc_bits = ^pc[1:0];

  assign idx = fetch_word[IDX_W-1:0];
  assign tag = fetch_word[WORD_W-1:IDX_W];
  assign hit = line_valid[idx] && (tag_mem[idx] == tag);

  // Next-state and per-cycle actions; core abort overrides every state.
  always_comb begin
    state_next = state;
    latch_pc   = 1'b0;
    load_hit   = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        state_next = LOOKUP;
        latch_pc   = 1'b1;
      end
      LOOKUP: begin
        if (hit) begin
          state_next = DONE;
          load_hit   = 1'b1;
        end else begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem.inst_mem_out_ready) begin
          state_next = DONE;
          fill       = 1'b1;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (fetcher_reset) begin
      state_next = IDLE;
      latch_pc   = 1'b0;
      load_hit   = 1'b0;
      fill       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                  <= IDLE;
      fetch_word             <= '0;
      line_valid             <= '0;
      instruction            <= '0;
      fetcher_completed      <= 1'b0;
      mem.inst_mem_out_valid <= 1'b0;
      mem.inst_mem_out_addr  <= '0;
    end else begin
      state                  <= state_next;
      fetcher_completed      <= (state_next == DONE);
      mem.inst_mem_out_valid <= (state_next == REQ);
      mem.inst_mem_out_addr  <= (state_next == REQ) ? {fetch_word, 2'b00} : 32'h0;
      if (latch_pc) begin
        fetch_word <= pc[31:2];
      end
      if (load_hit) begin
        instruction <= data_mem[idx];
      end else if (fill) begin
        instruction <= mem.inst_mem_out_data;
      end
      // A flush on the fill edge wins, leaving the new line invalid.
      if (cache_flush) begin
        line_valid <= '0;
      end else if (fill) begin
        line_valid[idx] <= 1'b1;
      end
    end
  end

  // Line storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (reset && fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem.inst_mem_out_data;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: cold miss, hit, conflict, abort, flush,
// unaligned pc and reset during an outstanding request.
module tb_inst_fetcher;

  logic        clk;
  logic        reset;
  logic        fetcher_reset;
  logic [31:0] pc;
  logic        cache_flush;
  logic        fetcher_completed;
  logic [31:0] instruction;

  int n_checks;
  int n_pass;

  inst_fetcher_if bus ();

  inst_fetcher #(.CACHE_LINES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetcher_reset     (fetcher_reset),
    .pc                (pc),
    .cache_flush       (cache_flush),
    .fetcher_completed (fetcher_completed),
    .instruction       (instruction),
    .mem               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full fetch starting from IDLE, ending back in IDLE.
  // flush_mode: 0 none, 1 flush on the lookup edge, 2 flush on the fill edge.
  task automatic fetch(input string tag, input logic [31:0] p, input bit hit,
                       input logic [31:0] exp_addr, input int stall,
                       input logic [31:0] word, input logic [31:0] exp_instr,
                       input int flush_mode);
    int cnt;
    int guard;
    logic [31:0] held;
    pc            = p;
    fetcher_reset = 1'b0;
    step();
    check({tag, ".lookup_cmp"}, 32'(fetcher_completed), 32'h0);
    if (flush_mode == 1) cache_flush = 1'b1;
    step();
    cache_flush = 1'b0;
    check({tag, ".cmp2"}, 32'(fetcher_completed), 32'(hit));
    check({tag, ".valid2"}, 32'(bus.inst_mem_out_valid), 32'(!hit));
    if (!hit) begin
      cnt   = 0;
      guard = 0;
      while (fetcher_completed !== 1'b1 && guard < 40) begin
        if (bus.inst_mem_out_valid === 1'b1) begin
          cnt++;
          check({tag, ".addr"}, bus.inst_mem_out_addr, exp_addr);
          pc = 32'hFFFF_FFF0;
          if (cnt == stall) begin
            bus.inst_mem_out_ready = 1'b1;
            bus.inst_mem_out_data  = word;
            if (flush_mode == 2) cache_flush = 1'b1;
          end
        end
        step();
        bus.inst_mem_out_ready = 1'b0;
        bus.inst_mem_out_data  = 32'h0;
        cache_flush            = 1'b0;
        guard++;
      end
      check({tag, ".stall_cycles"}, 32'(cnt), 32'(stall));
      check({tag, ".valid_after"}, 32'(bus.inst_mem_out_valid), 32'h0);
      check({tag, ".addr_after"}, bus.inst_mem_out_addr, 32'h0);
    end
    check({tag, ".instr"}, instruction, exp_instr);
    held = instruction;
    step();
    check({tag, ".hold_cmp"}, 32'(fetcher_completed), 32'h1);
    check({tag, ".hold_instr"}, instruction, held);
    fetcher_reset = 1'b1;
    step();
    check({tag, ".release_cmp"}, 32'(fetcher_completed), 32'h0);
  endtask

  // Miss whose response edge coincides with a core abort or a hard reset.
  task automatic abort_fetch(input string tag, input logic [31:0] p, input bit use_reset);
    pc            = p;
    fetcher_reset = 1'b0;
    step();
    step();
    check({tag, ".req_valid"}, 32'(bus.inst_mem_out_valid), 32'h1);
    bus.inst_mem_out_ready = 1'b1;
    bus.inst_mem_out_data  = 32'hBAD0_BAD0;
    if (use_reset) reset = 1'b0;
    else fetcher_reset = 1'b1;
    step();
    bus.inst_mem_out_ready = 1'b0;
    bus.inst_mem_out_data  = 32'h0;
    check({tag, ".valid"}, 32'(bus.inst_mem_out_valid), 32'h0);
    check({tag, ".addr"}, bus.inst_mem_out_addr, 32'h0);
    check({tag, ".cmp"}, 32'(fetcher_completed), 32'h0);
    if (use_reset) check({tag, ".instr"}, instruction, 32'h0);
    fetcher_reset = 1'b1;
    reset         = 1'b1;
    step();
    check({tag, ".idle_cmp"}, 32'(fetcher_completed), 32'h0);
  endtask

  initial begin
    n_checks               = 0;
    n_pass                 = 0;
    reset                  = 1'b0;
    fetcher_reset          = 1'b1;
    pc                     = 32'h0;
    cache_flush            = 1'b0;
    bus.inst_mem_out_ready = 1'b0;
    bus.inst_mem_out_data  = 32'h0;
    step();
    step();
    check("rst.cmp",   32'(fetcher_completed), 32'h0);
    check("rst.instr", instruction, 32'h0);
    check("rst.valid", 32'(bus.inst_mem_out_valid), 32'h0);
    check("rst.addr",  bus.inst_mem_out_addr, 32'h0);
    reset = 1'b1;
    step();

    fetch("cold",      32'h100, 1'b0, 32'h100, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    fetch("hit",       32'h100, 1'b1, 32'h0,   0, 32'h0,         32'hDEAD_BEEF, 0);
    fetch("conf_a",    32'h110, 1'b0, 32'h110, 1, 32'h1111_1111, 32'h1111_1111, 0);
    fetch("conf_b",    32'h100, 1'b0, 32'h100, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    abort_fetch("abort", 32'h200, 1'b0);
    fetch("post_abort", 32'h200, 1'b0, 32'h200, 1, 32'h2222_2222, 32'h2222_2222, 0);
    fetch("refill",    32'h100, 1'b0, 32'h100, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

    cache_flush = 1'b1;
    step();
    cache_flush = 1'b0;
    fetch("flushed",   32'h103, 1'b0, 32'h100, 1, 32'h3333_3333, 32'h3333_3333, 0);
    fetch("fill_flush", 32'h108, 1'b0, 32'h108, 1, 32'h4444_4444, 32'h4444_4444, 2);
    fetch("after_ff",  32'h108, 1'b0, 32'h108, 1, 32'h5555_5555, 32'h5555_5555, 0);
    fetch("lk_flush",  32'h108, 1'b1, 32'h0,   0, 32'h0,         32'h5555_5555, 1);
    fetch("after_lf",  32'h108, 1'b0, 32'h108, 1, 32'h6666_6666, 32'h6666_6666, 0);
    abort_fetch("rst_req", 32'h10C, 1'b1);
    fetch("post_rst",  32'h10C, 1'b0, 32'h10C, 1, 32'h7777_7777, 32'h7777_7777, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
